echo_mix_stage: RTL and testbench

//  Downstream consumer of the sample-storage stage in the audio delay/echo path.

---
 rtl/echo_mix_stage.sv | 201 ++++++++++++++++++++
 tb/tb_echo_mix_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/echo_mix_stage.sv
// echo_mix_stage
//   Joins a dry sample and a delayed sample arriving on independent
//   valid/ready links, scales the delayed sample by an unsigned fractional
//   gain (gain / 2^GAIN_W), adds it to the dry sample and presents the
//   result on a valid/ready link toward the codec serializer.
//
//   Build option: ECHO_MIX_SAT_EN
//     defined   -> result clamped to the DATA_W signed range, clip pulses
//     undefined -> result wraps to DATA_W bits, clip tied low
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | collecting dry and delayed samples; each ready high until held
//   MUL   | delayed sample times gain; mix_enable latched
//   ADD   | scale, add dry sample, register odata/ovalid/clip
//   OUT   | holding result until downstream accepts it

module echo_mix_stage #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 8
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dry_data,
    input  logic              dry_valid,
    output logic              dry_ready,
    input  logic [DATA_W-1:0] dly_data,
    input  logic              dly_valid,
    output logic              dly_ready,
    input  logic [GAIN_W-1:0] gain,
    input  logic              mix_enable,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    input  logic              oready,
    output logic              clip
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int SUM_W  = DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state, state_n;

    logic              dry_held, dry_held_n;
    logic              dly_held, dly_held_n;
    logic [DATA_W-1:0] dry_q, dry_q_n;
    logic [DATA_W-1:0] dly_q, dly_q_n;
    logic [PROD_W-1:0] prod_q, prod_n;
    logic              mix_q, mix_n;
    logic              dry_ready_n, dly_ready_n;
    logic [DATA_W-1:0] odata_n;
    logic              ovalid_n;
    logic              clip_n;

    logic              dry_take, dly_take;
    logic signed [PROD_W-1:0] dly_ext, gain_ext;
    logic signed [SUM_W-1:0]  dry_ext, scaled_ext, sum_w;
    logic [DATA_W-1:0] mix_data;
    logic              mix_clip;

    assign dry_take = dry_valid & dry_ready;
    assign dly_take = dly_valid & dly_ready;

    // Gain is a positive fraction, so it is zero-extended before the signed multiply.
    assign dly_ext  = {{(GAIN_W+1){dly_q[DATA_W-1]}}, dly_q};
    assign gain_ext = {{(DATA_W+1){1'b0}}, gain};

    // Dropping the low GAIN_W product bits is an arithmetic shift that rounds toward -inf.
    assign dry_ext    = {{2{dry_q[DATA_W-1]}}, dry_q};
    assign scaled_ext = {prod_q[PROD_W-1], prod_q[PROD_W-1:GAIN_W]};
    assign sum_w      = mix_q ? (dry_ext + scaled_ext) : dry_ext;

`ifdef ECHO_MIX_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    // Clamp the widened sum into the output range and flag when it happens.
    always_comb begin
        mix_data = sum_w[DATA_W-1:0];
        mix_clip = 1'b0;
        if (sum_w > SAT_MAX) begin
            mix_data = SAT_MAX[DATA_W-1:0];
            mix_clip = 1'b1;
        end else if (sum_w < SAT_MIN) begin
            mix_data = SAT_MIN[DATA_W-1:0];
            mix_clip = 1'b1;
        end
    end
`else
    logic unused_sum_hi;

    assign mix_data      = sum_w[DATA_W-1:0];
    assign mix_clip      = 1'b0;
    assign unused_sum_hi = ^sum_w[SUM_W-1:DATA_W];
`endif

    // State register.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Held samples, datapath pipeline and registered outputs.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            dry_held  <= 1'b0;
            dly_held  <= 1'b0;
            dry_q     <= '0;
            dly_q     <= '0;
            prod_q    <= '0;
            mix_q     <= 1'b0;
            dry_ready <= 1'b0;
            dly_ready <= 1'b0;
            odata     <= '0;
            ovalid    <= 1'b0;
            clip      <= 1'b0;
        end else begin
            dry_held  <= dry_held_n;
            dly_held  <= dly_held_n;
            dry_q     <= dry_q_n;
            dly_q     <= dly_q_n;
            prod_q    <= prod_n;
            mix_q     <= mix_n;
            dry_ready <= dry_ready_n;
            dly_ready <= dly_ready_n;
            odata     <= odata_n;
            ovalid    <= ovalid_n;
            clip      <= clip_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n     = state;
        dry_held_n  = dry_held;
        dly_held_n  = dly_held;
        dry_q_n     = dry_q;
        dly_q_n     = dly_q;
        prod_n      = prod_q;
        mix_n       = mix_q;
        dry_ready_n = 1'b0;
        dly_ready_n = 1'b0;
        odata_n     = odata;
        ovalid_n    = ovalid;
        clip_n      = 1'b0;

        case (state)
            IDLE: begin
                if (dry_take) begin
                    dry_held_n = 1'b1;
                    dry_q_n    = dry_data;
                end
                if (dly_take) begin
                    dly_held_n = 1'b1;
                    dly_q_n    = dly_data;
                end
                if (dry_held_n && dly_held_n) begin
                    state_n = MUL;
                end else begin
                    dry_ready_n = ~dry_held_n;
                    dly_ready_n = ~dly_held_n;
                end
            end
            MUL: begin
                prod_n  = dly_ext * gain_ext;
                mix_n   = mix_enable;
                state_n = ADD;
            end
            ADD: begin
                odata_n  = mix_data;
                ovalid_n = 1'b1;
                clip_n   = mix_clip;
                state_n  = OUT;
            end
            OUT: begin
                // Reopening both links on the accept edge keeps 4-cycle throughput.
                if (oready) begin
                    ovalid_n    = 1'b0;
                    dry_held_n  = 1'b0;
                    dly_held_n  = 1'b0;
                    dry_ready_n = 1'b1;
                    dly_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_echo_mix_stage.sv
// tb_echo_mix_stage
//   Directed bench for echo_mix_stage. Expected mixed samples come from a
//   small integer model and are queued when stimulus is driven, then popped
//   when the DUT presents ovalid. Honours ECHO_MIX_SAT_EN like the DUT.

module tb_echo_mix_stage;

    logic        clk100 = 1'b0;
    logic        rst_n;
    logic [15:0] dry_data;
    logic        dry_valid;
    logic        dry_ready;
    logic [15:0] dly_data;
    logic        dly_valid;
    logic        dly_ready;
    logic [7:0]  gain;
    logic        mix_enable;
    logic [15:0] odata;
    logic        ovalid;
    logic        oready;
    logic        clip;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];

    echo_mix_stage #(.DATA_W(16), .GAIN_W(8)) dut (
        .clk100     (clk100),
        .rst_n      (rst_n),
        .dry_data   (dry_data),
        .dry_valid  (dry_valid),
        .dry_ready  (dry_ready),
        .dly_data   (dly_data),
        .dly_valid  (dly_valid),
        .dly_ready  (dly_ready),
        .gain       (gain),
        .mix_enable (mix_enable),
        .odata      (odata),
        .ovalid     (ovalid),
        .oready     (oready),
        .clip       (clip)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {clip, odata}.
    function automatic logic [16:0] model(input int dry, input int dly, input int g, input bit mix);
        int sum;
        logic [31:0] s;
        sum = mix ? dry + ((dly * g) >>> 8) : dry;
`ifdef ECHO_MIX_SAT_EN
        if (sum > 32767)  return {1'b1, 16'h7fff};
        if (sum < -32768) return {1'b1, 16'h8000};
`endif
        s = sum;
        return {1'b0, s[15:0]};
    endfunction

    // Offer both samples starting at the given cycle offsets; returns at the
    // falling edge after the edge that captured the second sample.
    task automatic run_txn(input int dry, input int dly, input int g, input bit mix,
                           input int dry_off, input int dly_off, input bit push);
        bit dry_done = 0;
        bit dly_done = 0;
        bit dry_cap, dly_cap;
        int c = 0;
        logic [31:0] dv, lv;
        dv = dry;
        lv = dly;
        gain       = g[7:0];
        mix_enable = mix;
        if (push) exp_q.push_back(model(dry, dly, g, mix));
        while (!(dry_done && dly_done) && c < 50) begin
            if (c == dry_off) begin dry_valid = 1'b1; dry_data = dv[15:0]; end
            if (c == dly_off) begin dly_valid = 1'b1; dly_data = lv[15:0]; end
            if (dry_done) check("dry_ready_while_waiting", dry_ready, 0);
            if (dly_done) check("dly_ready_while_waiting", dly_ready, 0);
            dry_cap = dry_valid && dry_ready;
            dly_cap = dly_valid && dly_ready;
            @(posedge clk100);
            @(negedge clk100);
            if (dry_cap) begin dry_done = 1; dry_valid = 1'b0; end
            if (dly_cap) begin dly_done = 1; dly_valid = 1'b0; end
            c++;
        end
        check("capture_done", {31'd0, dry_done && dly_done}, 1);
        dry_valid = 1'b0;
        dly_valid = 1'b0;
    endtask

    // Wait for the mixed sample, compare against the scoreboard, optionally
    // stall downstream for 'hold' cycles, then confirm the link reopens.
    task automatic wait_out(input int hold, input string tag);
        int k = 0;
        logic [16:0] e;
        while (!ovalid && k < 20) begin
            @(negedge clk100);
            k++;
        end
        check({tag, "_latency"}, k, 2);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_odata"}, odata, e[15:0]);
        check({tag, "_clip"}, clip, e[16]);
        check({tag, "_readies_busy"}, {dry_ready, dly_ready}, 0);
        if (hold > 0) begin
            oready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk100);
                check({tag, "_hold_ovalid"}, ovalid, 1);
                check({tag, "_hold_odata"}, odata, e[15:0]);
                check({tag, "_hold_clip"}, clip, 0);
                check({tag, "_hold_readies"}, {dry_ready, dly_ready}, 0);
            end
            oready = 1'b1;
        end
        @(negedge clk100);
        check({tag, "_ovalid_drop"}, ovalid, 0);
        check({tag, "_readies_reopen"}, {dry_ready, dly_ready}, 2'b11);
    endtask

    initial begin
        rst_n      = 1'b0;
        dry_data   = '0;
        dry_valid  = 1'b0;
        dly_data   = '0;
        dly_valid  = 1'b0;
        gain       = '0;
        mix_enable = 1'b1;
        oready     = 1'b1;

        repeat (3) @(negedge clk100);
        check("rst_ovalid", ovalid, 0);
        check("rst_odata", odata, 0);
        check("rst_clip", clip, 0);
        check("rst_readies", {dry_ready, dly_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk100);
        check("readies_after_rst", {dry_ready, dly_ready}, 2'b11);

        // Same-cycle arrival.
        run_txn(1000, 2000, 128, 1, 0, 0, 1);
        wait_out(0, "t1");

        // Dry first, then delayed first.
        run_txn(1000, 2000, 128, 1, 0, 5, 1);
        wait_out(0, "t2a");
        run_txn(1000, 2000, 128, 1, 5, 0, 1);
        wait_out(0, "t2b");

        // Overflow in both directions.
        run_txn(32000, 32000, 255, 1, 0, 0, 1);
        wait_out(0, "t3pos");
        run_txn(-32000, -32000, 255, 1, 0, 1, 1);
        wait_out(0, "t3neg");

        // Downstream stall.
        run_txn(-3000, 4000, 64, 1, 0, 0, 1);
        wait_out(10, "t4");

        // Mixing disabled still consumes the delayed sample.
        run_txn(-500, 30000, 200, 0, 0, 2, 1);
        wait_out(0, "t5");

        // Zero gain and floor rounding of a negative product.
        run_txn(1234, -5000, 0, 1, 0, 0, 1);
        wait_out(0, "gain0");
        run_txn(10, -3, 100, 1, 0, 0, 1);
        wait_out(0, "floor");

        run_txn(0, -1, 1, 1, 0, 0, 1);
        wait_out(0, "t6");

        // Reset asserted while in ADD discards the in-flight sample.
        run_txn(0, -1, 1, 1, 0, 0, 0);
        @(posedge clk100);
        #2 rst_n = 1'b0;
        #1;
        check("rst_add_ovalid", ovalid, 0);
        check("rst_add_readies", {dry_ready, dly_ready}, 0);
        check("rst_add_odata", odata, 0);
        @(negedge clk100);
        check("rst_add_hold_ovalid", ovalid, 0);
        rst_n = 1'b1;
        @(negedge clk100);
        check("rst_add_readies_rise", {dry_ready, dly_ready}, 2'b11);
        repeat (4) begin
            @(negedge clk100);
            check("rst_add_no_output", ovalid, 0);
        end

        // Back-to-back after reset to confirm the pipeline is clean.
        run_txn(-20000, 10000, 128, 1, 0, 0, 1);
        wait_out(0, "post_rst");

        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
